udp_tx: RTL and testbench

- UDP transmit engine; counterpart of the UDP receive path in the eth stack.
- Reads a prepared payload from an external 8x2048 payload RAM and computes the UDP checksum over pseudo-header, header and payload.
- Requests the IP layer, then streams the 8-byte UDP header plus payload as a contiguous byte stream into IP/MAC framing.

---
 rtl/udp_tx.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_udp_tx.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx.sv
`default_nettype none
// ============================================================================
// Module   : udp_tx
// Brief    : UDP transmit engine. Reads a prepared payload from an external
//            payload RAM. It can checksum the pseudo-header, the header and
//            the payload. It then requests the IP layer and streams the 8-byte
//            UDP header followed by the payload as one contiguous byte stream.
// Options  : UDP_TX_CHECKSUM_EN - when defined, the CALC/FOLD phases compute
//            the UDP checksum. When undefined, the checksum field is 0x0000.
// Revision : 1.0 - initial release
// ============================================================================
module udp_tx #(
  parameter int RAM_AW      = 11,
  parameter int MAX_PAYLOAD = 1472,
  parameter int ACK_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              udp_tx_req,
  input  logic [15:0]       udp_tx_data_length,
  input  logic [15:0]       udp_src_port,
  input  logic [15:0]       udp_dst_port,
  input  logic [31:0]       ip_src_addr,
  input  logic [31:0]       ip_dst_addr,
  output logic [RAM_AW-1:0] udp_tx_ram_read_addr,
  input  logic [7:0]        udp_tx_ram_rdata,
  output logic              ip_tx_req,
  output logic [15:0]       ip_tx_length,
  input  logic              ip_tx_ack,
  output logic [7:0]        udp_tx_data,
  output logic              udp_tx_valid,
  output logic              udp_tx_last,
  output logic              udp_tx_busy,
  output logic              udp_tx_done,
  output logic              udp_tx_error
);

  localparam int                WAIT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
`ifdef UDP_TX_CHECKSUM_EN
    S_CALC = 3'd1,
    S_FOLD = 3'd2,
`endif
    S_WAIT = 3'd3,
    S_HEAD = 3'd4,
    S_DATA = 3'd5,
    S_END  = 3'd6
  } state_t;

  state_t            state_q;
  state_t            state_d;

  // Fields latched when a request is accepted
  logic [15:0]       len_q;
  logic [15:0]       ulen_q;
  logic [15:0]       sport_q;
  logic [15:0]       dport_q;
  logic [15:0]       csum_q;

  // step_q counts fold cycles, header bytes and payload bytes (one phase at a time)
  logic [15:0]       step_q;
  logic [WAIT_W-1:0] wait_q;
  logic [RAM_AW-1:0] addr_q;
  logic              err_q;

  logic [15:0]       ulen_in;
  logic              len_ok;
  logic [RAM_AW-1:0] last_addr;
  logic              accept;
  logic              reject;
  logic              timeout;
  logic [7:0]        hdr_byte;

  assign ulen_in   = udp_tx_data_length + 16'd8;
  assign len_ok    = (udp_tx_data_length != 16'd0) &&
                     (udp_tx_data_length <= 16'(MAX_PAYLOAD));
  assign last_addr = len_q[RAM_AW-1:0] - RAM_AW'(1);

  assign udp_tx_ram_read_addr = addr_q;
  assign udp_tx_error         = err_q;

`ifdef UDP_TX_CHECKSUM_EN
  logic [31:0] acc_q;
  logic [31:0] acc_init;
  logic [31:0] rd_word;
  logic [31:0] fold1;
  logic [15:0] csum_calc;
  logic        rd_vld_q;
  logic        rd_odd_q;

  // Pseudo-header plus UDP header; the checksum field itself counts as zero
  assign acc_init = 32'(ip_src_addr[31:16]) + 32'(ip_src_addr[15:0]) +
                    32'(ip_dst_addr[31:16]) + 32'(ip_dst_addr[15:0]) +
                    32'h0000_0011 + 32'(ulen_in) +
                    32'(udp_src_port) + 32'(udp_dst_port) + 32'(ulen_in);

  // Even-indexed bytes are the high half of a big-endian word; a lone final
  // byte is therefore implicitly padded with 0x00.
  assign rd_word   = rd_odd_q ? {24'h0, udp_tx_ram_rdata} : {16'h0, udp_tx_ram_rdata, 8'h00};
  assign fold1     = {16'h0, acc_q[15:0]} + {16'h0, acc_q[31:16]};
  assign csum_calc = (fold1[15:0] == 16'hFFFF) ? 16'hFFFF : ~fold1[15:0];

  // Accumulate payload words as RAM data returns, then apply the first fold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_odd_q <= 1'b0;
    end else begin
      rd_vld_q <= (state_q == S_CALC);
      rd_odd_q <= addr_q[0];
      if (accept) begin
        acc_q <= acc_init;
      end else if (rd_vld_q) begin
        acc_q <= acc_q + rd_word;
      end else if ((state_q == S_FOLD) && (step_q == 16'd1)) begin
        acc_q <= fold1;
      end
    end
  end
`else
  // The pseudo-header addresses only feed the checksum
  logic unused_ip_addrs;
  assign unused_ip_addrs = ^{ip_src_addr, ip_dst_addr};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Header byte selected by position within the 8-byte header
  always_comb begin
    hdr_byte = 8'h00;
    case (step_q[2:0])
      3'd0:    hdr_byte = sport_q[15:8];
      3'd1:    hdr_byte = sport_q[7:0];
      3'd2:    hdr_byte = dport_q[15:8];
      3'd3:    hdr_byte = dport_q[7:0];
      3'd4:    hdr_byte = ulen_q[15:8];
      3'd5:    hdr_byte = ulen_q[7:0];
      3'd6:    hdr_byte = csum_q[15:8];
      default: hdr_byte = csum_q[7:0];
    endcase
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    reject       = 1'b0;
    timeout      = 1'b0;
    ip_tx_req    = 1'b0;
    ip_tx_length = 16'h0000;
    udp_tx_data  = 8'h00;
    udp_tx_valid = 1'b0;
    udp_tx_last  = 1'b0;
    udp_tx_done  = 1'b0;
    udp_tx_busy  = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (udp_tx_req) begin
          if (len_ok) begin
            accept = 1'b1;
`ifdef UDP_TX_CHECKSUM_EN
            state_d = S_CALC;
`else
            state_d = S_WAIT;
`endif
          end else begin
            reject = 1'b1;
          end
        end
      end
`ifdef UDP_TX_CHECKSUM_EN
      S_CALC: begin
        if (addr_q == last_addr) begin
          state_d = S_FOLD;
        end
      end
      S_FOLD: begin
        if (step_q == 16'd2) begin
          state_d = S_WAIT;
        end
      end
`endif
      S_WAIT: begin
        ip_tx_req    = 1'b1;
        ip_tx_length = ulen_q;
        if (ip_tx_ack) begin
          state_d = S_HEAD;
        end else if (wait_q == WAIT_LAST) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_HEAD: begin
        udp_tx_valid = 1'b1;
        udp_tx_data  = hdr_byte;
        if (step_q == 16'd7) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        udp_tx_valid = 1'b1;
        udp_tx_data  = udp_tx_ram_rdata;
        if (step_q == (len_q - 16'd1)) begin
          udp_tx_last = 1'b1;
          state_d     = S_END;
        end
      end
      S_END: begin
        udp_tx_done = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Field latching, RAM addressing, phase counters and the error pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q   <= '0;
      ulen_q  <= '0;
      sport_q <= '0;
      dport_q <= '0;
      csum_q  <= '0;
      step_q  <= '0;
      wait_q  <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= reject | timeout;
      case (state_q)
        S_IDLE: begin
          addr_q <= '0;
          step_q <= '0;
          wait_q <= '0;
          if (accept) begin
            len_q   <= udp_tx_data_length;
            ulen_q  <= ulen_in;
            sport_q <= udp_src_port;
            dport_q <= udp_dst_port;
            csum_q  <= '0;
          end
        end
`ifdef UDP_TX_CHECKSUM_EN
        S_CALC: begin
          addr_q <= (addr_q == last_addr) ? '0 : addr_q + RAM_AW'(1);
        end
        S_FOLD: begin
          if (step_q == 16'd2) begin
            csum_q <= csum_calc;
            step_q <= '0;
          end else begin
            step_q <= step_q + 16'd1;
          end
        end
`endif
        S_WAIT: begin
          step_q <= '0;
          wait_q <= ip_tx_ack ? '0 : wait_q + WAIT_W'(1);
        end
        S_HEAD: begin
          // Address 0 is presented during the last header byte, so the
          // next address is already queued when payload streaming begins.
          if (step_q == 16'd7) begin
            step_q <= '0;
            addr_q <= (len_q > 16'd1) ? RAM_AW'(1) : '0;
          end else begin
            step_q <= step_q + 16'd1;
          end
        end
        S_DATA: begin
          step_q <= step_q + 16'd1;
          addr_q <= ((addr_q != '0) && (addr_q != last_addr)) ? addr_q + RAM_AW'(1) : '0;
        end
        S_END: begin
          step_q <= '0;
          addr_q <= '0;
        end
        default: begin
          addr_q <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_udp_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_tx
// Brief    : Self-checking bench for udp_tx: table vectors, random frames
//            against a one's-complement reference model, and hand-written
//            timeout / reset / re-request sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_tx;

  localparam int RAM_AW      = 11;
  localparam int MAX_PAYLOAD = 1472;
  localparam int ACK_TO      = 40;
`ifdef UDP_TX_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req;
  logic [15:0]       len;
  logic [15:0]       sport;
  logic [15:0]       dport;
  logic [31:0]       sip;
  logic [31:0]       dip;
  logic [RAM_AW-1:0] raddr;
  logic [7:0]        rdata;
  logic              ip_req;
  logic [15:0]       ip_len;
  logic              ack;
  logic [7:0]        data;
  logic              valid;
  logic              last;
  logic              busy;
  logic              done;
  logic              err;

  udp_tx #(
    .RAM_AW      (RAM_AW),
    .MAX_PAYLOAD (MAX_PAYLOAD),
    .ACK_TIMEOUT (ACK_TO)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .udp_tx_req           (req),
    .udp_tx_data_length   (len),
    .udp_src_port         (sport),
    .udp_dst_port         (dport),
    .ip_src_addr          (sip),
    .ip_dst_addr          (dip),
    .udp_tx_ram_read_addr (raddr),
    .udp_tx_ram_rdata     (rdata),
    .ip_tx_req            (ip_req),
    .ip_tx_length         (ip_len),
    .ip_tx_ack            (ack),
    .udp_tx_data          (data),
    .udp_tx_valid         (valid),
    .udp_tx_last          (last),
    .udp_tx_busy          (busy),
    .udp_tx_done          (done),
    .udp_tx_error         (err)
  );

  always #5 clk = ~clk;

  // Payload RAM with one cycle of read latency
  logic [7:0] mem [0:(1<<RAM_AW)-1];
  always @(posedge clk) rdata <= mem[raddr];

  // ---------------------------------------------------------------- monitor
  logic [7:0] cap[$];
  int  last_cnt, last_pos, done_cnt, err_cnt, req_cycles, busy_cycles;
  int  runs, addr_viol, len_viol, cur_len;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (valid) begin
      cap.push_back(data);
      if (!prev_valid) runs++;
      if (last) begin
        last_cnt++;
        last_pos = cap.size();
      end
    end
    prev_valid = valid;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (ip_req) begin
      req_cycles++;
      if (ip_len != 16'(cur_len + 8)) len_viol++;
    end
    if (busy) busy_cycles++;
    if (cur_len > 0 && int'(raddr) > cur_len - 1) addr_viol++;
    if (!busy && raddr != '0) addr_viol++;
  end

  // ---------------------------------------------------------------- checking
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon;
    cap.delete();
    last_cnt = 0; last_pos = 0; done_cnt = 0; err_cnt = 0;
    req_cycles = 0; busy_cycles = 0; runs = 0; addr_viol = 0; len_viol = 0;
  endtask

  // ---------------------------------------------------------------- model
  logic [7:0] exp_q[$];

`ifdef UDP_TX_CHECKSUM_EN
  // One's-complement addition with end-around carry
  function automatic int unsigned oc_add(input int unsigned s, input logic [15:0] w);
    int unsigned t;
    t = s + 32'(w);
    if (t > 32'hFFFF) t = t - 32'hFFFF;
    return t;
  endfunction
`endif

  function automatic void model(input int l, input logic [15:0] sp, input logic [15:0] dp,
                                input logic [31:0] si, input logic [31:0] di);
    logic [15:0] ul;
    logic [15:0] cs;
`ifdef UDP_TX_CHECKSUM_EN
    int unsigned s;
    logic [7:0]  lo;
`endif
    ul = 16'(l + 8);
`ifdef UDP_TX_CHECKSUM_EN
    s = 0;
    s = oc_add(s, si[31:16]);
    s = oc_add(s, si[15:0]);
    s = oc_add(s, di[31:16]);
    s = oc_add(s, di[15:0]);
    s = oc_add(s, 16'h0011);
    s = oc_add(s, ul);
    s = oc_add(s, sp);
    s = oc_add(s, dp);
    s = oc_add(s, ul);
    for (int k = 0; k < l; k += 2) begin
      lo = (k + 1 < l) ? mem[k+1] : 8'h00;
      s  = oc_add(s, {mem[k], lo});
    end
    cs = ~s[15:0];
    if (cs == 16'h0000) cs = 16'hFFFF;
`else
    cs = 16'h0000;
`endif
    exp_q.delete();
    exp_q.push_back(sp[15:8]); exp_q.push_back(sp[7:0]);
    exp_q.push_back(dp[15:8]); exp_q.push_back(dp[7:0]);
    exp_q.push_back(ul[15:8]); exp_q.push_back(ul[7:0]);
    exp_q.push_back(cs[15:8]); exp_q.push_back(cs[7:0]);
    for (int k = 0; k < l; k++) exp_q.push_back(mem[k]);
  endfunction

  // ---------------------------------------------------------------- sequences
  task automatic run_frame(input string tag, input int l, input logic [15:0] sp,
                           input logic [15:0] dp, input logic [31:0] si,
                           input logic [31:0] di, input int ack_dly, input bit mid_req);
    int lat;
    int n;
    int nmis;
    bit pulsed;
    clear_mon();
    cur_len = l;
    model(l, sp, dp, si, di);
    req = 1'b1; len = 16'(l); sport = sp; dport = dp; sip = si; dip = di;
    tick();
    req = 1'b0; len = 16'($urandom); sport = 16'($urandom); dport = 16'($urandom);
    sip = $urandom; dip = $urandom;
    lat = 1;
    while (!ip_req && lat < l + 50) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, CK_EN ? l + 4 : 1);
    repeat (ack_dly) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n = 0;
    pulsed = 1'b0;
    while (done_cnt == 0 && n < l + 100) begin
      tick();
      n++;
      if (mid_req && !pulsed && cap.size() == 3) begin
        req = 1'b1; len = 16'd7;
        tick();
        req = 1'b0;
        pulsed = 1'b1;
        n++;
      end
    end
    repeat (12) tick();
    nmis = 0;
    for (int k = 0; k < exp_q.size(); k++)
      if (k >= cap.size() || cap[k] !== exp_q[k]) nmis++;
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_frame_len"}, cap.size(), l + 8);
    check({tag, "_bytes_wrong"}, nmis, 0);
    check({tag, "_last_count"}, last_cnt, 1);
    check({tag, "_last_pos"}, last_pos, l + 8);
    check({tag, "_valid_runs"}, runs, 1);
    check({tag, "_req_cycles"}, req_cycles, ack_dly + 1);
    check({tag, "_ip_len_bad"}, len_viol, 0);
    check({tag, "_addr_bad"}, addr_viol, 0);
    check({tag, "_err_count"}, err_cnt, 0);
    check({tag, "_idle_after"}, busy, 0);
  endtask

  task automatic run_reject(input string tag, input int l);
    clear_mon();
    cur_len = 0;
    req = 1'b1; len = 16'(l);
    tick();
    req = 1'b0;
    check({tag, "_err_pulse"}, err, 1);
    repeat (5) tick();
    check({tag, "_err_count"}, err_cnt, 1);
    check({tag, "_req_cycles"}, req_cycles, 0);
    check({tag, "_busy_cycles"}, busy_cycles, 0);
    check({tag, "_bytes"}, cap.size(), 0);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    int          len;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [31:0] si;
    logic [31:0] di;
    int          ack_dly;
    logic [39:0] pay;       // first five payload bytes, MSB first
    bit          exp_err;
    bit          has_csum;
    logic [15:0] csum;      // checksum when computed
  } vec_t;

  vec_t vt[6];

  initial begin
    int n;
    int l;
    vt[0] = '{4,    16'h1F90, 16'h1F90, 32'hC0A8010A, 32'hC0A80164, 3, 40'hDEADBEEF00, 1'b0, 1'b1, 16'h9F59};
    vt[1] = '{5,    16'h1F90, 16'h1F90, 32'hC0A8010A, 32'hC0A80164, 0, 40'h0102030405, 1'b0, 1'b1, 16'h33EF};
    vt[2] = '{0,    16'h1234, 16'h5678, 32'h0A000001, 32'h0A000002, 0, 40'h0,          1'b1, 1'b0, 16'h0};
    vt[3] = '{1473, 16'h1234, 16'h5678, 32'h0A000001, 32'h0A000002, 0, 40'h0,          1'b1, 1'b0, 16'h0};
    vt[4] = '{1,    16'h0035, 16'hC000, 32'h08080808, 32'hC0A80001, 1, 40'hAA00000000, 1'b0, 1'b0, 16'h0};
    vt[5] = '{1472, 16'hFFFF, 16'h0001, 32'hFFFFFFFF, 32'h00000000, 2, 40'h0,          1'b0, 1'b0, 16'h0};

    rst_n = 1'b0; req = 1'b0; ack = 1'b0; len = '0; sport = '0; dport = '0; sip = '0; dip = '0;
    cur_len = 0;
    for (int k = 0; k < (1 << RAM_AW); k++) mem[k] = 8'h00;
    repeat (3) tick();
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ip_req", ip_req, 0);
    check("rst_done_err", {done, err, last}, 0);
    check("rst_addr_data", {raddr, data, ip_len}, 0);
    rst_n = 1'b1;
    tick();

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vt[i].len && k < (1 << RAM_AW); k++)
        mem[k] = (k < 5) ? vt[i].pay[39 - 8*k -: 8] : 8'(k * 7 + 3);
      if (vt[i].exp_err) begin
        run_reject($sformatf("vec%0d", i), vt[i].len);
      end else begin
        run_frame($sformatf("vec%0d", i), vt[i].len, vt[i].sp, vt[i].dp, vt[i].si, vt[i].di,
                  vt[i].ack_dly, 1'b0);
        if (vt[i].has_csum)
          check($sformatf("vec%0d_csum", i),
                (cap.size() >= 8) ? {cap[6], cap[7]} : 32'hDEAD0000,
                CK_EN ? vt[i].csum : 16'h0000);
      end
    end

    // Random frames against the reference model
    for (int i = 0; i < 20; i++) begin
      l = (i == 19) ? int'($urandom_range(200, 300)) : int'($urandom_range(1, 64));
      for (int k = 0; k < l; k++) mem[k] = 8'($urandom);
      run_frame($sformatf("rnd%0d", i), l, 16'($urandom), 16'($urandom), $urandom, $urandom,
                int'($urandom_range(0, 10)), 1'b0);
    end

    // Second request mid-frame is ignored
    for (int k = 0; k < 16; k++) mem[k] = 8'($urandom);
    run_frame("midreq", 16, 16'h0400, 16'h0401, 32'h0A0A0A0A, 32'h0B0B0B0B, 2, 1'b1);

    // No acknowledge: request held for the timeout, then error and idle
    clear_mon();
    cur_len = 8;
    req = 1'b1; len = 16'd8; sport = 16'h1111; dport = 16'h2222; sip = 32'h01020304; dip = 32'h05060708;
    tick();
    req = 1'b0;
    n = 0;
    while (err_cnt == 0 && n < 8 + 4 + ACK_TO + 50) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check("timeout_req_cycles", req_cycles, ACK_TO);
    check("timeout_err_count", err_cnt, 1);
    check("timeout_bytes", cap.size(), 0);
    check("timeout_done", done_cnt, 0);
    check("timeout_idle", busy, 0);

    // Reset during payload byte 20 of a 100-byte frame
    clear_mon();
    cur_len = 100;
    for (int k = 0; k < 100; k++) mem[k] = 8'($urandom);
    req = 1'b1; len = 16'd100; sport = 16'h3333; dport = 16'h4444; sip = 32'hAC100001; dip = 32'hAC100002;
    tick();
    req = 1'b0;
    n = 0;
    while (!ip_req && n < 200) begin
      tick();
      n++;
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n = 0;
    while (cap.size() < 28 && n < 200) begin
      tick();
      n++;
    end
    check("rstmid_reached", cap.size(), 28);
    rst_n = 1'b0;
    tick();
    check("rstmid_valid", valid, 0);
    check("rstmid_last", last, 0);
    check("rstmid_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("rstmid_no_more_bytes", cap.size(), 28);
    mem[0] = 8'hDE; mem[1] = 8'hAD; mem[2] = 8'hBE; mem[3] = 8'hEF;
    run_frame("after_rst", 4, 16'h1F90, 16'h1F90, 32'hC0A8010A, 32'hC0A80164, 3, 1'b0);
    check("after_rst_csum", (cap.size() >= 8) ? {cap[6], cap[7]} : 32'hDEAD0000,
          CK_EN ? 16'h9F59 : 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
